// File: rtl/raster_scheduler.sv
// Frame sequencer: clears framebuffer/Z-buffer, dispatches triangles to the
// rasterizer one at a time, muxes the BRAM write ports and handshakes the buffer swap.
module raster_scheduler #(
  parameter int         FB_W     = 320,
  parameter int         FB_H     = 240,
  parameter int         FB_DEPTH = FB_W * FB_H,
  parameter logic [7:0] CLEAR_Z  = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic [7:0]  bg_color,
  input  logic        frame_end,
  output logic        frame_done,
  output logic        busy,
  input  logic        tri_valid,
  output logic        tri_ready,
  output logic        rast_start,
  input  logic        rast_done,
  input  logic        r_fb_we,
  input  logic [16:0] r_fb_addr,
  input  logic [7:0]  r_fb_din,
  input  logic        r_zb_we,
  input  logic [16:0] r_zb_addr,
  input  logic [7:0]  r_zb_din,
  output logic        fb_we,
  output logic [16:0] fb_addr,
  output logic [7:0]  fb_din,
  output logic        zb_en,
  output logic        zb_we,
  output logic [16:0] zb_addr,
  output logic [7:0]  zb_din,
  output logic        swap_req,
  input  logic        swap_ack,
  output logic [15:0] tri_count,
  output logic        cmd_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_READY,
    S_RASTER,
    S_SWAP
  } state_t;

  localparam logic [16:0] LAST_ADDR = 17'(FB_DEPTH - 1);

  state_t      state_q, state_d;
  logic        clr_we_q;
  logic [16:0] fb_addr_q, zb_addr_q;
  logic [7:0]  fb_din_q, zb_din_q;
  logic        rast_start_q, frame_done_q, end_pending_q, cmd_err_q;
  logic [15:0] tri_count_q;
  logic        last_clear, in_raster;

  // During CLEAR the framebuffer address register doubles as the clear counter.
  assign last_clear = (fb_addr_q == LAST_ADDR);
  assign in_raster  = (state_q == S_RASTER);

  // NOTE: every sequential block uses non-blocking assignments so all registers
  // update together from pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (frame_start) state_d = S_CLEAR;
      S_CLEAR:  if (last_clear) state_d = S_READY;
      S_READY: begin
        if (tri_valid)      state_d = S_RASTER;
        else if (frame_end) state_d = S_SWAP;
      end
      S_RASTER: if (rast_done) state_d = (end_pending_q || frame_end) ? S_SWAP : S_READY;
      S_SWAP:   if (swap_ack) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_we_q      <= 1'b0;
      fb_addr_q     <= '0;
      zb_addr_q     <= '0;
      fb_din_q      <= '0;
      zb_din_q      <= '0;
      rast_start_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      end_pending_q <= 1'b0;
      tri_count_q   <= '0;
      cmd_err_q     <= 1'b0;
    end else begin
      rast_start_q <= (state_q == S_READY) && tri_valid;
      frame_done_q <= (state_q == S_SWAP) && swap_ack;
      case (state_q)
        S_IDLE: begin
          if (frame_start) begin
            clr_we_q      <= 1'b1;
            fb_addr_q     <= '0;
            zb_addr_q     <= '0;
            fb_din_q      <= bg_color;
            zb_din_q      <= CLEAR_Z;
            tri_count_q   <= '0;
            end_pending_q <= 1'b0;
          end
          if (frame_end) cmd_err_q <= 1'b1;
        end
        S_CLEAR: begin
          if (last_clear) begin
            clr_we_q <= 1'b0;
          end else begin
            fb_addr_q <= fb_addr_q + 17'd1;
            zb_addr_q <= zb_addr_q + 17'd1;
          end
          if (frame_start || frame_end) cmd_err_q <= 1'b1;
        end
        S_READY: begin
          if (tri_valid && frame_end) end_pending_q <= 1'b1;
        end
        S_RASTER: begin
          // Track the pass-through values so the ports hold them once RASTER ends.
          fb_addr_q <= r_fb_addr;
          fb_din_q  <= r_fb_din;
          zb_addr_q <= r_zb_addr;
          zb_din_q  <= r_zb_din;
          if (frame_end) end_pending_q <= 1'b1;
          if (rast_done && tri_count_q != 16'hFFFF) tri_count_q <= tri_count_q + 16'd1;
          if (frame_start) cmd_err_q <= 1'b1;
        end
        S_SWAP: begin
          if (frame_start) cmd_err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Rasterizer owns the BRAM ports combinationally in RASTER to keep its read timing.
  assign fb_we   = in_raster ? r_fb_we   : clr_we_q;
  assign fb_addr = in_raster ? r_fb_addr : fb_addr_q;
  assign fb_din  = in_raster ? r_fb_din  : fb_din_q;
  assign zb_en   = in_raster | clr_we_q;
  assign zb_we   = in_raster ? r_zb_we   : clr_we_q;
  assign zb_addr = in_raster ? r_zb_addr : zb_addr_q;
  assign zb_din  = in_raster ? r_zb_din  : zb_din_q;

  assign tri_ready  = (state_q == S_READY);
  assign busy       = (state_q != S_IDLE);
  assign swap_req   = (state_q == S_SWAP);
  assign rast_start = rast_start_q;
  assign frame_done = frame_done_q;
  assign tri_count  = tri_count_q;
  assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_raster_scheduler.sv
// Self-checking bench for raster_scheduler: vector table, directed corner
// sequences and randomized frames scored against a behavioural BRAM image.
module tb_raster_scheduler;

  localparam int FB_W  = 20;
  localparam int FB_H  = 12;
  localparam int DEPTH = FB_W * FB_H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start, frame_end, tri_valid, rast_done, swap_ack;
  logic [7:0]  bg_color;
  logic        frame_done, busy, tri_ready, rast_start, swap_req, cmd_err;
  logic        r_fb_we, r_zb_we, fb_we, zb_en, zb_we;
  logic [16:0] r_fb_addr, r_zb_addr, fb_addr, zb_addr;
  logic [7:0]  r_fb_din, r_zb_din, fb_din, zb_din;
  logic [15:0] tri_count;

  raster_scheduler #(
    .FB_W(FB_W), .FB_H(FB_H), .FB_DEPTH(DEPTH), .CLEAR_Z(8'hFF)
  ) dut (
    .clk(clk), .rst(rst),
    .frame_start(frame_start), .bg_color(bg_color), .frame_end(frame_end),
    .frame_done(frame_done), .busy(busy),
    .tri_valid(tri_valid), .tri_ready(tri_ready),
    .rast_start(rast_start), .rast_done(rast_done),
    .r_fb_we(r_fb_we), .r_fb_addr(r_fb_addr), .r_fb_din(r_fb_din),
    .r_zb_we(r_zb_we), .r_zb_addr(r_zb_addr), .r_zb_din(r_zb_din),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_din(fb_din),
    .zb_en(zb_en), .zb_we(zb_we), .zb_addr(zb_addr), .zb_din(zb_din),
    .swap_req(swap_req), .swap_ack(swap_ack),
    .tri_count(tri_count), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  // BRAMs driven by the DUT, and the image software expects to end up in them.
  logic [7:0] fb_mem [0:131071];
  logic [7:0] zb_mem [0:131071];
  logic [7:0] exp_fb [0:DEPTH-1];
  logic [7:0] exp_zb [0:DEPTH-1];

  always @(posedge clk) begin
    if (fb_we) fb_mem[fb_addr] <= fb_din;
    if (zb_en && zb_we) zb_mem[zb_addr] <= zb_din;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [79:0] all_outs();
    return {5'b0, frame_done, busy, tri_ready, rast_start, fb_we, fb_addr, fb_din,
            zb_en, zb_we, zb_addr, zb_din, swap_req, tri_count, cmd_err};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    frame_start = 0; frame_end = 0; tri_valid = 0; rast_done = 0; swap_ack = 0;
    bg_color = 0;
    r_fb_we = 0; r_fb_addr = 0; r_fb_din = 0;
    r_zb_we = 0; r_zb_addr = 0; r_zb_din = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) tick();
    check("reset_outputs", all_outs(), 80'd0);
    rst = 1'b1;
    tick();
  endtask

  task automatic start_frame(input logic [7:0] bg);
    frame_start = 1; bg_color = bg;
    tick();
    frame_start = 0;
    for (int a = 0; a < DEPTH; a++) begin
      exp_fb[a] = bg;
      exp_zb[a] = 8'hFF;
    end
  endtask

  task automatic wait_ready(input string name);
    int k = 0;
    while (!tri_ready && k < DEPTH + 10) begin
      tick();
      k++;
    end
    check(name, tri_ready, 1'b1);
  endtask

  task automatic wait_fb_addr(input int target);
    int k = 0;
    while (fb_addr != 17'(target) && k < DEPTH + 10) begin
      tick();
      k++;
    end
    check("reach_clear_addr", fb_addr, 17'(target));
  endtask

  task automatic compare_mem(input string name);
    int bad_fb = 0, bad_zb = 0;
    for (int a = 0; a < DEPTH; a++) begin
      if (fb_mem[a] !== exp_fb[a]) bad_fb++;
      if (zb_mem[a] !== exp_zb[a]) bad_zb++;
    end
    check({name, "_fb_mem"}, bad_fb, 0);
    check({name, "_zb_mem"}, bad_zb, 0);
  endtask

  typedef struct {
    logic        fs, fe, tv, rd, sa;
    logic        busy, rdy, rs, sreq, fd;
    logic [15:0] cnt;
    logic        err;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    #2;
    do_reset();

    // Full clear: one write per cycle, addresses 0..DEPTH-1, then READY.
    start_frame(8'h3C);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("clear_%0d", i),
            {fb_we, zb_en, zb_we, fb_addr, fb_din, zb_addr, zb_din, tri_ready},
            {1'b1, 1'b1, 1'b1, 17'(i), 8'h3C, 17'(i), 8'hFF, 1'b0});
      tick();
    end
    check("ready_after_clear", {tri_ready, fb_we, zb_en, busy}, 4'b1001);

    // One triangle with same-cycle BRAM pass-through.
    tri_valid = 1;
    tick();
    tri_valid = 0;
    check("rast_start_pulse", {rast_start, tri_ready}, 2'b10);
    r_fb_we = 1; r_fb_addr = 17'd1000; r_fb_din = 8'h55;
    r_zb_we = 1; r_zb_addr = 17'd1000; r_zb_din = 8'h10;
    #1;
    check("passthrough", {fb_we, fb_addr, fb_din, zb_en, zb_we, zb_addr, zb_din},
          {1'b1, 17'd1000, 8'h55, 1'b1, 1'b1, 17'd1000, 8'h10});
    tick();
    check("rast_start_one_cycle", rast_start, 1'b0);
    r_fb_we = 0; r_zb_we = 0; rast_done = 1;
    tick();
    rast_done = 0;
    check("first_tri_done", {tri_count, tri_ready}, {16'd1, 1'b1});
    check("ports_held", {fb_we, zb_en, fb_addr, fb_din, zb_addr, zb_din},
          {1'b0, 1'b0, 17'd1000, 8'h55, 17'd1000, 8'h10});
    clear_inputs();

    // Cycle-by-cycle protocol table, starting in READY with one triangle done.
    //            fs fe tv rd sa  busy rdy rs sreq fd  cnt    err
    vecs[0]  = '{0, 0, 0, 0, 0,  1,   1,  0, 0,   0,  16'd1, 0};
    vecs[1]  = '{0, 0, 1, 0, 0,  1,   0,  1, 0,   0,  16'd1, 0};
    vecs[2]  = '{0, 0, 0, 0, 0,  1,   0,  0, 0,   0,  16'd1, 0};
    vecs[3]  = '{0, 0, 0, 1, 0,  1,   1,  0, 0,   0,  16'd2, 0};
    vecs[4]  = '{0, 0, 1, 0, 0,  1,   0,  1, 0,   0,  16'd2, 0};
    vecs[5]  = '{0, 1, 0, 0, 0,  1,   0,  0, 0,   0,  16'd2, 0};
    vecs[6]  = '{0, 0, 0, 0, 0,  1,   0,  0, 0,   0,  16'd2, 0};
    vecs[7]  = '{0, 0, 0, 1, 0,  1,   0,  0, 1,   0,  16'd3, 0};
    vecs[8]  = '{0, 0, 0, 0, 0,  1,   0,  0, 1,   0,  16'd3, 0};
    vecs[9]  = '{1, 0, 0, 0, 0,  1,   0,  0, 1,   0,  16'd3, 1};
    vecs[10] = '{0, 0, 0, 0, 1,  0,   0,  0, 0,   1,  16'd3, 1};
    vecs[11] = '{0, 0, 0, 0, 0,  0,   0,  0, 0,   0,  16'd3, 1};
    for (int i = 0; i < 12; i++) begin
      frame_start = vecs[i].fs; frame_end = vecs[i].fe; tri_valid = vecs[i].tv;
      rast_done = vecs[i].rd; swap_ack = vecs[i].sa;
      tick();
      check($sformatf("vec_%0d", i),
            {busy, tri_ready, rast_start, swap_req, frame_done, tri_count, cmd_err},
            {vecs[i].busy, vecs[i].rdy, vecs[i].rs, vecs[i].sreq, vecs[i].fd,
             vecs[i].cnt, vecs[i].err});
    end
    clear_inputs();

    // Three triangles, frame_end, swap_ack withheld for 50 cycles.
    do_reset();
    start_frame(8'hA5);
    wait_ready("ready_f3");
    for (int t = 0; t < 3; t++) begin
      tri_valid = 1; tick(); tri_valid = 0;
      tick();
      rast_done = 1; tick(); rast_done = 0;
    end
    frame_end = 1; tick(); frame_end = 0;
    check("swap_req_rise", {swap_req, tri_count}, {1'b1, 16'd3});
    begin
      int low = 0;
      for (int c = 0; c < 50; c++) begin
        tick();
        if (!swap_req || frame_done) low++;
      end
      check("swap_req_held_50", low, 0);
    end
    swap_ack = 1; tick(); swap_ack = 0;
    check("frame_done_f3", {frame_done, busy, swap_req, tri_count}, {1'b1, 1'b0, 1'b0, 16'd3});
    tick();
    check("frame_done_one_cycle", frame_done, 1'b0);
    compare_mem("f3");

    // tri_valid and frame_end together: triangle first, then SWAP.
    start_frame(8'h0F);
    wait_ready("ready_simul");
    tri_valid = 1; frame_end = 1; tick(); tri_valid = 0; frame_end = 0;
    check("simul_dispatch", {rast_start, swap_req, tri_ready}, 3'b100);
    repeat (2) tick();
    check("simul_no_swap_yet", swap_req, 1'b0);
    rast_done = 1; tick(); rast_done = 0;
    check("simul_swap", {swap_req, tri_count}, {1'b1, 16'd1});
    swap_ack = 1; tick(); swap_ack = 0;
    check("simul_done", {frame_done, cmd_err}, 2'b10);

    // Illegal commands: frame_end in IDLE, frame_start mid-clear.
    frame_end = 1; tick(); frame_end = 0;
    check("err_frame_end_idle", {cmd_err, busy}, 2'b10);
    start_frame(8'h77);
    wait_fb_addr(100);
    frame_start = 1; bg_color = 8'h99; tick(); frame_start = 0;
    begin
      int bad = 0;
      for (int a = 101; a < DEPTH; a++) begin
        if (fb_addr != 17'(a) || !fb_we || fb_din != 8'h77) bad++;
        tick();
      end
      check("clear_uninterrupted", bad, 0);
    end
    check("err_after_clear", {tri_ready, cmd_err}, 2'b11);

    // Asynchronous reset mid-clear, then a clean restart at address 0.
    do_reset();
    start_frame(8'h11);
    wait_fb_addr(120);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_outputs", all_outs(), 80'd0);
    tick();
    rst = 1'b1;
    tick();
    start_frame(8'h22);
    check("restart_addr0", {fb_we, fb_addr, fb_din, zb_addr}, {1'b1, 17'd0, 8'h22, 17'd0});
    do_reset();

    // Randomized frames against the expected BRAM image.
    for (int f = 0; f < 10; f++) begin
      int n, mode;
      start_frame(8'($urandom));
      wait_ready($sformatf("rnd%0d_ready", f));
      n    = $urandom_range(0, 5);
      mode = (n == 0) ? 0 : $urandom_range(0, 2);
      for (int t = 0; t < n; t++) begin
        int len;
        logic last;
        last = (t == n - 1);
        tri_valid = 1;
        frame_end = last && mode == 1;
        tick();
        tri_valid = 0; frame_end = 0;
        len = $urandom_range(1, 6);
        for (int c = 0; c < len; c++) begin
          r_fb_we = 1'($urandom); r_fb_addr = 17'($urandom_range(0, DEPTH - 1));
          r_fb_din = 8'($urandom);
          r_zb_we = 1'($urandom); r_zb_addr = 17'($urandom_range(0, DEPTH - 1));
          r_zb_din = 8'($urandom);
          if (r_fb_we) exp_fb[r_fb_addr] = r_fb_din;
          if (r_zb_we) exp_zb[r_zb_addr] = r_zb_din;
          frame_end = last && mode == 2 && c == 0;
          tick();
          frame_end = 0;
        end
        r_fb_we = 0; r_zb_we = 0; rast_done = 1;
        tick();
        rast_done = 0;
      end
      if (mode == 0) begin
        frame_end = 1; tick(); frame_end = 0;
      end
      begin
        int d, bad;
        d = $urandom_range(0, 8);
        bad = 0;
        for (int c = 0; c < d; c++) begin
          if (!swap_req) bad++;
          tick();
        end
        if (!swap_req) bad++;
        check($sformatf("rnd%0d_swap_req", f), bad, 0);
      end
      swap_ack = 1; tick(); swap_ack = 0;
      check($sformatf("rnd%0d_done", f), {frame_done, busy, tri_count, cmd_err},
            {1'b1, 1'b0, 16'(n), 1'b0});
      compare_mem($sformatf("rnd%0d", f));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
